// File: rtl/commit_controller_pkg.sv
// Shared ROB/commit encodings: head instruction types and commit FSM states.
package commit_controller_pkg;

  typedef enum logic [1:0] {
    HT_REG    = 2'd0,
    HT_STORE  = 2'd1,
    HT_BRANCH = 2'd2,
    HT_HALT   = 2'd3
  } head_type_e;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_STORE_WAIT = 2'd1,
    S_FLUSH      = 2'd2,
    S_HALT       = 2'd3
  } commit_state_e;

endpackage

// File: rtl/commit_controller.sv
// In-order commit controller for the ROB head: register writes, store handshake,
// mispredict flush and halt. Optional commitCount output when COMMIT_COUNTER_EN is defined.
module commit_controller
  import commit_controller_pkg::*;
#(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 readyIn,
  input  logic                 headValid,
  input  logic                 headReady,
  input  logic [ROB_WIDTH-1:0] headId,
  input  logic [1:0]           headType,
  input  logic [4:0]           headRd,
  input  logic [31:0]          headValue,
  input  logic                 headMispredict,
  input  logic [31:0]          headTarget,
  output logic                 commitAck,
  output logic                 regWriteFlag,
  output logic [ROB_WIDTH-1:0] regRobId,
  output logic [4:0]           regWriteAddr,
  output logic [31:0]          regWriteValue,
  output logic                 storeReq,
  input  logic                 storeAck,
  output logic                 clearOut,
  output logic                 redirectFlag,
  output logic [31:0]          redirectPc,
  output logic                 haltOut
`ifdef COMMIT_COUNTER_EN
  ,
  output logic [31:0]          commitCount
`endif
);

  commit_state_e state;
  head_type_e    htype;
  logic          headGo;
  logic          storeDone;

  assign htype = head_type_e'(headType);

  // Reset masks the Mealy outputs so an aborted store never acks.
  assign headGo    = (state == S_IDLE) && readyIn && headValid && headReady && !resetIn;
  assign storeDone = (state == S_STORE_WAIT) && readyIn && storeAck && !resetIn;

  assign commitAck     = (headGo && (htype != HT_STORE)) || storeDone;
  assign regWriteFlag  = headGo && ((htype == HT_REG) || (htype == HT_BRANCH)) && (headRd != 5'd0);
  assign regRobId      = headId;
  assign regWriteAddr  = headRd;
  assign regWriteValue = headValue;

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      state        <= S_IDLE;
      storeReq     <= 1'b0;
      clearOut     <= 1'b0;
      redirectFlag <= 1'b0;
      haltOut      <= 1'b0;
      redirectPc   <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (headGo) begin
            case (htype)
              HT_STORE: begin
                state    <= S_STORE_WAIT;
                storeReq <= 1'b1;
              end
              HT_BRANCH: begin
                if (headMispredict) begin
                  state        <= S_FLUSH;
                  redirectPc   <= headTarget;
                  clearOut     <= 1'b1;
                  redirectFlag <= 1'b1;
                end
              end
              HT_HALT: begin
                state   <= S_HALT;
                haltOut <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_STORE_WAIT: begin
          if (storeDone) begin
            state    <= S_IDLE;
            storeReq <= 1'b0;
          end
        end
        // Flush is a fixed one-cycle pulse; readyIn does not stretch it.
        S_FLUSH: begin
          state        <= S_IDLE;
          clearOut     <= 1'b0;
          redirectFlag <= 1'b0;
        end
        S_HALT: ;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef COMMIT_COUNTER_EN
  always_ff @(posedge clockIn) begin
    if (resetIn)
      commitCount <= 32'd0;
    else if (commitAck)
      commitCount <= commitCount + 32'd1;
  end
`endif

endmodule

// File: tb/tb_commit_controller.sv
// Directed plus randomized bench for commit_controller against a flag-based reference model.
module tb_commit_controller;

  logic        clockIn = 1'b0;
  logic        resetIn, readyIn, headValid, headReady, headMispredict, storeAck;
  logic [3:0]  headId;
  logic [1:0]  headType;
  logic [4:0]  headRd;
  logic [31:0] headValue, headTarget;
  logic        commitAck, regWriteFlag, storeReq, clearOut, redirectFlag, haltOut;
  logic [3:0]  regRobId;
  logic [4:0]  regWriteAddr;
  logic [31:0] regWriteValue, redirectPc;
`ifdef COMMIT_COUNTER_EN
  logic [31:0] commitCount;
`endif

  commit_controller #(.ROB_WIDTH(4)) dut (
    .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn),
    .headValid(headValid), .headReady(headReady), .headId(headId),
    .headType(headType), .headRd(headRd), .headValue(headValue),
    .headMispredict(headMispredict), .headTarget(headTarget),
    .commitAck(commitAck), .regWriteFlag(regWriteFlag), .regRobId(regRobId),
    .regWriteAddr(regWriteAddr), .regWriteValue(regWriteValue),
    .storeReq(storeReq), .storeAck(storeAck), .clearOut(clearOut),
    .redirectFlag(redirectFlag), .redirectPc(redirectPc), .haltOut(haltOut)
`ifdef COMMIT_COUNTER_EN
    , .commitCount(commitCount)
`endif
  );

  always #5 clockIn = ~clockIn;

  int nCmp = 0;
  int nErr = 0;
  int nAck = 0;

  // Reference model: what the controller is waiting on, in plain terms.
  bit          mStorePending, mFlushNow, mHalted;
  logic [31:0] mRedirect, mCount;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setHead(input bit v, input bit r, input logic [3:0] id, input logic [1:0] t,
                         input logic [4:0] rd, input logic [31:0] val, input bit mis,
                         input logic [31:0] tgt);
    headValid = v; headReady = r; headId = id; headType = t; headRd = rd;
    headValue = val; headMispredict = mis; headTarget = tgt;
  endtask

  // Check one cycle at the falling edge, then advance the model across the rising edge.
  task automatic tick();
    bit canTake, take, eAck, eWr;
    @(negedge clockIn);
    canTake = !mStorePending && !mFlushNow && !mHalted;
    take = !resetIn && readyIn && canTake && headValid && headReady;
    eAck = (take && headType != 2'd1) || (!resetIn && readyIn && mStorePending && storeAck);
    eWr  = take && (headType == 2'd0 || headType == 2'd2) && headRd != 5'd0;
    chk("commitAck", {31'd0, commitAck}, {31'd0, eAck});
    chk("regWriteFlag", {31'd0, regWriteFlag}, {31'd0, eWr});
    if (eWr) begin
      chk("regRobId", {28'd0, regRobId}, {28'd0, headId});
      chk("regWriteAddr", {27'd0, regWriteAddr}, {27'd0, headRd});
      chk("regWriteValue", regWriteValue, headValue);
    end
    chk("storeReq", {31'd0, storeReq}, {31'd0, mStorePending});
    chk("clearOut", {31'd0, clearOut}, {31'd0, mFlushNow});
    chk("redirectFlag", {31'd0, redirectFlag}, {31'd0, mFlushNow});
    chk("haltOut", {31'd0, haltOut}, {31'd0, mHalted});
    chk("redirectPc", redirectPc, mRedirect);
`ifdef COMMIT_COUNTER_EN
    chk("commitCount", commitCount, mCount);
`endif
    if (commitAck === 1'b1) nAck++;
    if (resetIn) begin
      mStorePending = 0; mFlushNow = 0; mHalted = 0; mRedirect = 0; mCount = 0;
    end else begin
      if (eAck) mCount = mCount + 1;
      mFlushNow = 0;
      if (mStorePending && readyIn && storeAck) mStorePending = 0;
      if (take) begin
        if (headType == 2'd1) mStorePending = 1;
        if (headType == 2'd3) mHalted = 1;
        if (headType == 2'd2 && headMispredict) begin
          mFlushNow = 1;
          mRedirect = headTarget;
        end
      end
    end
    @(posedge clockIn);
    #1;
  endtask

  initial begin
    resetIn = 1; readyIn = 1; storeAck = 0;
    setHead(0, 0, 0, 0, 0, 0, 0, 0);
    mStorePending = 0; mFlushNow = 0; mHalted = 0; mRedirect = 0; mCount = 0;
    @(posedge clockIn); #1;
    tick(); tick();
    resetIn = 0;

    // REG burst rd=5,6,7
    setHead(1, 1, 4'd1, 2'd0, 5'd5, 32'h11, 0, 0); tick();
    setHead(1, 1, 4'd2, 2'd0, 5'd6, 32'h22, 0, 0); tick();
    setHead(1, 1, 4'd3, 2'd0, 5'd7, 32'h33, 0, 0); tick();
    // rd=0 suppresses the register write
    setHead(1, 1, 4'd4, 2'd0, 5'd0, 32'hFFFF, 0, 0); tick();
    // Store with the ack four cycles late, then a REG head
    setHead(1, 1, 4'd5, 2'd1, 5'd0, 32'h0, 0, 0); tick();
    repeat (3) tick();
    storeAck = 1; tick();
    storeAck = 0;
    setHead(1, 1, 4'd6, 2'd0, 5'd9, 32'h99, 0, 0); tick();
    // Stray storeAck in IDLE is ignored
    setHead(0, 0, 0, 0, 0, 0, 0, 0); storeAck = 1; tick();
    storeAck = 0;
    // Mispredicted branch, ready head during FLUSH must not be acked
    setHead(1, 1, 4'd7, 2'd2, 5'd1, 32'h44, 1, 32'h1000); tick();
    setHead(1, 1, 4'd8, 2'd0, 5'd2, 32'h55, 0, 0); tick();
    tick();
    // Stall with a ready head
    readyIn = 0; tick(); tick();
    readyIn = 1;
    // Reset during STORE_WAIT with an ack present
    setHead(1, 1, 4'd9, 2'd1, 5'd0, 0, 0, 0); tick();
    setHead(0, 0, 0, 0, 0, 0, 0, 0); tick();
    resetIn = 1; storeAck = 1; tick();
    resetIn = 0; storeAck = 0; tick();
    // Halt stays sticky until reset
    setHead(1, 1, 4'd10, 2'd3, 5'd0, 0, 0, 0); tick();
    setHead(1, 1, 4'd11, 2'd0, 5'd3, 32'h77, 0, 0); repeat (4) tick();
    resetIn = 1; tick();
    resetIn = 0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      resetIn = ($urandom_range(0, 79) == 0);
      readyIn = ($urandom_range(0, 5) != 0);
      storeAck = ($urandom_range(0, 2) == 0);
      setHead($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 4'($urandom),
              ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
              $urandom, $urandom_range(0, 3) == 0, $urandom);
      tick();
    end

`ifdef COMMIT_COUNTER_EN
    resetIn = 1; tick(); resetIn = 0; nAck = 0;
    setHead(1, 1, 4'd1, 2'd0, 5'd4, 32'h1, 0, 0); repeat (5) tick();
    setHead(0, 0, 0, 0, 0, 0, 0, 0); tick();
    @(negedge clockIn);
    chk("commitCount_vs_acks", commitCount, 32'(nAck));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
